// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder
// Brief    : MEM-stage data-memory responder. It serves loads and stores with a
//            fixed-latency stall handshake toward the pipeline control unit.
//            Optional macro DRAM_MISALIGN_CHK_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module dram_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              misalign_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lo_q;
    logic [31:0]      wdata_q;
    logic             mis_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem_q [DEPTH];

    logic             w_accept, w_commit, w_mis;
    logic             w_is_b, w_is_h;
    logic [1:0]       w_lo;
    logic             w_op_we;
    logic [2:0]       w_op_f3;
    logic [IDX_W-1:0] w_op_idx;
    logic [1:0]       w_op_lo;
    logic [31:0]      w_op_wdata;
    logic [31:0]      w_word, w_load, w_wrep;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [3:0]       w_be;
    logic             w_unused_addr;

    assign w_unused_addr = ^addr_i[ADDR_W-1:IDX_W+2];

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word
    assign w_is_b = (funct3_i[1:0] == 2'b00);
    assign w_is_h = (funct3_i[1:0] == 2'b01);

`ifdef DRAM_MISALIGN_CHK_EN
    assign w_lo  = addr_i[1:0];
    assign w_mis = (w_is_h && addr_i[0]) || (!w_is_b && !w_is_h && (addr_i[1:0] != 2'b00));
`else
    assign w_lo  = w_is_b ? addr_i[1:0] : (w_is_h ? {addr_i[1], 1'b0} : 2'b00);
    assign w_mis = 1'b0;
`endif

    assign w_accept = (state_q == S_IDLE) && (re_i || we_i);

    // A single-cycle latency commits straight from the inputs in IDLE.
    assign w_op_we    = (state_q == S_IDLE) ? we_i                   : we_q;
    assign w_op_f3    = (state_q == S_IDLE) ? funct3_i               : f3_q;
    assign w_op_idx   = (state_q == S_IDLE) ? addr_i[IDX_W+1:2]      : idx_q;
    assign w_op_lo    = (state_q == S_IDLE) ? w_lo                   : lo_q;
    assign w_op_wdata = (state_q == S_IDLE) ? wdata_i                : wdata_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_mis) begin
                        state_d = S_DONE;
                    end else begin
                        stall_o = 1'b1;
                        if (LATENCY == 1) begin
                            w_commit = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d   = CNT_W'(LATENCY - 1);
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    w_commit = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_word = mem_q[w_op_idx];
        w_byte = w_word[{w_op_lo, 3'b000} +: 8];
        w_half = w_op_lo[1] ? w_word[31:16] : w_word[15:0];
        case (w_op_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (w_op_f3[1:0])
            2'b00: begin
                w_wrep = {4{w_op_wdata[7:0]}};
                w_be   = 4'b0001 << w_op_lo;
            end
            2'b01: begin
                w_wrep = {2{w_op_wdata[15:0]}};
                w_be   = w_op_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wrep = w_op_wdata;
                w_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= we_i;
                f3_q    <= funct3_i;
                idx_q   <= addr_i[IDX_W+1:2];
                lo_q    <= w_lo;
                wdata_q <= wdata_i;
                mis_q   <= w_mis;
            end
            if (w_commit && !w_op_we) begin
                rdata_q <= w_load;
            end
        end
    end

    // Memory contents survive reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_op_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_op_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign misalign_o = (state_q == S_DONE) && mis_q;

endmodule
`default_nettype wire
